// File: rtl/ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_pkg : opcode/state encodings and instruction field slices for ctrl_seq
// Rev 1.0
// ----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_XOR = 3'b010,
    OP_BNE = 3'b011,
    OP_LS  = 3'b100,
    OP_RS  = 3'b101,
    OP_LW  = 3'b110,
    OP_STR = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // BNE r0,r0 doubles as the halt marker and is never executed
  localparam logic [8:0] HALT_INSTR = 9'b011_000_000;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RA_MSB = 5;
  localparam int RA_LSB = 3;
  localparam int RB_MSB = 2;
  localparam int RB_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_decode : opcode to instruction-class flags
// Rev 1.0
// ----------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  op_t  op,
  output logic is_alu,
  output logic is_br,
  output logic is_ld,
  output logic is_st
);

  always_comb begin
    is_alu = 1'b0;
    is_br  = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    case (op)
      OP_AND, OP_ADD, OP_XOR, OP_LS, OP_RS: is_alu = 1'b1;
      OP_BNE:                               is_br  = 1'b1;
      OP_LW:                                is_ld  = 1'b1;
      OP_STR:                               is_st  = 1'b1;
      default:                              ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ctrl_seq : multicycle control sequencer (PC, fetch/decode FSM, retire count)
// Rev 1.0
// ----------------------------------------------------------------------------
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  output logic [2:0]       rf_ra,
  output logic [2:0]       rf_rb,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic [2:0]       alu_cmd,
  input  logic [7:0]       alu_rslt,
  input  logic             branch_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [7:0]       dmem_addr,
  input  logic             dmem_ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state, next_state;
  op_t              op;
  logic [PC_W-1:0]  pc, pc_inc;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [8:0]       instr_q;
  logic             is_alu, is_br, is_ld, is_st;

  assign op      = op_t'(instr_q[OP_MSB:OP_LSB]);
  assign pc_inc  = pc + PC_W'(1);
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  assign imem_addr = pc;
  assign alu_cmd   = instr_q[OP_MSB:OP_LSB];
  assign rf_ra     = instr_q[RA_MSB:RA_LSB];
  assign rf_rb     = instr_q[RB_MSB:RB_LSB];
  assign instr_cnt = cnt;

  ctrl_decode u_decode (
    .op     (op),
    .is_alu (is_alu),
    .is_br  (is_br),
    .is_ld  (is_ld),
    .is_st  (is_st)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_HALT: if (start) next_state = S_FETCH;
      S_FETCH:        next_state = S_DECODE;
      S_DECODE:       next_state = (imem_data == HALT_INSTR) ? S_HALT : S_EXEC;
      S_EXEC:         next_state = (is_ld || is_st) ? S_MEM : S_FETCH;
      S_MEM:          if (dmem_ack) next_state = is_ld ? S_WB : S_FETCH;
      S_WB:           next_state = S_FETCH;
      default:        next_state = S_IDLE;
    endcase
  end

  // Moore outputs so an async reset drops requests/write-enables at once
  always_comb begin
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_FETCH, S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy  = 1'b1;
        rf_we = is_alu;
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = is_st;
      end
      S_WB: begin
        busy    = 1'b1;
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      cnt       <= '0;
      instr_q   <= '0;
      dmem_addr <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) begin
          pc  <= '0;
          cnt <= '0;
        end
        S_DECODE: instr_q <= imem_data;
        S_EXEC: begin
          if (is_alu) begin
            pc  <= pc_inc;
            cnt <= cnt_inc;
          end
          if (is_br) begin
            pc  <= branch_pc ? PC_W'(alu_rslt) : pc_inc;
            cnt <= cnt_inc;
          end
          if (is_ld || is_st) dmem_addr <= alu_rslt;
        end
        S_MEM: if (dmem_ack && is_st) begin
          pc  <= pc_inc;
          cnt <= cnt_inc;
        end
        S_WB: begin
          pc  <= pc_inc;
          cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ctrl_seq : directed + randomized bench for ctrl_seq with an
// instruction-level reference model (PC / retire count / per-class latency)
// ----------------------------------------------------------------------------
module tb_ctrl_seq;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 6;
  localparam int PC_MAX  = (1 << PC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [8:0] HALT_WORD = 9'b011_000_000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       imem_data;
  logic [2:0]       rf_ra, rf_rb;
  logic             rf_we, rf_wsel;
  logic [2:0]       alu_cmd;
  logic [7:0]       alu_rslt;
  logic             branch_pc;
  logic             dmem_req, dmem_we;
  logic [7:0]       dmem_addr;
  logic             dmem_ack;
  logic             busy, done;
  logic [CNT_W-1:0] instr_cnt;

  logic [8:0] imem [0:PC_MAX];

  int checks   = 0;
  int failures = 0;
  int m_pc     = 0;
  int m_cnt    = 0;

  ctrl_seq #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .alu_cmd   (alu_cmd),
    .alu_rslt  (alu_rslt),
    .branch_pc (branch_pc),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_ack  (dmem_ack),
    .busy      (busy),
    .done      (done),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory: data valid the cycle after the address
  always @(posedge clk) imem_data <= imem[imem_addr];

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // randomise inputs the DUT must ignore in the current cycle
  task automatic jiggle();
    alu_rslt  = 8'($urandom);
    branch_pc = 1'($urandom);
    dmem_ack  = 1'($urandom);
    start     = 1'($urandom);
  endtask

  function automatic int retire(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_imem_addr"}, 32'(imem_addr), 0);
    check({tag, "_alu_cmd"},   32'(alu_cmd), 0);
    check({tag, "_ra_rb"},     32'({rf_ra, rf_rb}), 0);
    check({tag, "_ctl"},       32'({rf_we, rf_wsel, dmem_req, dmem_we, busy, done}), 0);
    check({tag, "_dmem_addr"}, 32'(dmem_addr), 0);
    check({tag, "_cnt"},       32'(instr_cnt), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc  = 0;
    m_cnt = 0;
    check("start_busy_done", 32'({busy, done}), 32'b10);
  endtask

  // Called in a FETCH cycle; returns in the next FETCH cycle.
  task automatic exec_instr(input logic [8:0] ins, input logic [7:0] rslt,
                            input logic br, input int ack_dly);
    logic [2:0] op;
    logic       alu_op;
    op     = ins[8:6];
    alu_op = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    check("fetch_pc",   32'(imem_addr), m_pc);
    check("fetch_cnt",  32'(instr_cnt), m_cnt);
    check("fetch_busy", 32'(busy), 1);
    check("fetch_idle", 32'({rf_we, dmem_req}), 0);
    imem[m_pc] = ins;
    jiggle(); tick();
    jiggle(); tick();
    check("exec_cmd",   32'(alu_cmd), 32'(op));
    check("exec_ra_rb", 32'({rf_ra, rf_rb}), 32'(ins[5:0]));
    check("exec_ctl",   32'({rf_we, rf_wsel, dmem_req}), alu_op ? 32'b100 : 32'b000);
    jiggle();
    alu_rslt  = rslt;
    branch_pc = br;
    tick();
    if (op == 3'd3) begin
      m_pc  = br ? int'(rslt) : ((m_pc + 1) & PC_MAX);
      m_cnt = retire(m_cnt);
    end else if (op >= 3'd6) begin
      for (int i = 0; i <= ack_dly; i++) begin
        check("mem_req",  32'(dmem_req), 1);
        check("mem_we",   32'(dmem_we), 32'(op == 3'd7));
        check("mem_addr", 32'(dmem_addr), 32'(rslt));
        check("mem_rfwe", 32'(rf_we), 0);
        alu_rslt  = 8'($urandom);
        branch_pc = 1'($urandom);
        start     = 1'($urandom);
        dmem_ack  = (i == ack_dly);
        tick();
      end
      dmem_ack = 1'b0;
      if (op == 3'd6) begin
        check("wb_ctl", 32'({rf_we, rf_wsel, dmem_req}), 32'b110);
        jiggle();
        tick();
      end
      m_pc  = (m_pc + 1) & PC_MAX;
      m_cnt = retire(m_cnt);
    end else begin
      m_pc  = (m_pc + 1) & PC_MAX;
      m_cnt = retire(m_cnt);
    end
  endtask

  task automatic run_halt();
    check("halt_fetch_pc",  32'(imem_addr), m_pc);
    check("halt_fetch_cnt", 32'(instr_cnt), m_cnt);
    imem[m_pc] = HALT_WORD;
    jiggle(); tick();
    jiggle(); start = 1'b0; tick();
    check("halt_done_busy", 32'({done, busy}), 32'b10);
    check("halt_cnt",       32'(instr_cnt), m_cnt);
    check("halt_ctl",       32'({rf_we, dmem_req}), 0);
    tick();
    check("halt_hold", 32'({done, busy}), 32'b10);
  endtask

  function automatic logic [8:0] rand_alu();
    logic [2:0] ops [5];
    logic [5:0] regs;
    ops  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    regs = 6'($urandom);
    return {ops[$urandom_range(0, 4)], regs};
  endfunction

  initial begin
    logic [8:0] ins;
    int         guard;
    for (int i = 0; i <= PC_MAX; i++) imem[i] = 9'h0;
    reset = 1'b1; start = 1'b0; alu_rslt = 8'h0; branch_pc = 1'b0; dmem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_vals("rst");

    // ADD r1,r2 ; HALT
    do_start();
    exec_instr(9'b001_001_010, 8'h37, 1'b0, 0);
    run_halt();

    // BNE taken / not taken, LW with late ack, STR with immediate ack
    do_start();
    exec_instr(9'b011_001_010, 8'h20, 1'b1, 0);
    exec_instr(9'b011_001_010, 8'h55, 1'b0, 0);
    exec_instr(9'b110_011_100, 8'h44, 1'b0, 3);
    exec_instr(9'b111_010_001, 8'h99, 1'b0, 0);
    for (int n = 0; n < 40; n++) begin
      ins = 9'($urandom);
      if (ins == HALT_WORD) ins[0] = 1'b1;
      exec_instr(ins, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    run_halt();

    // PC wrap at the top of instruction memory; retire count saturates
    do_start();
    exec_instr(9'b011_001_010, 8'hFF, 1'b1, 0);
    guard = 0;
    while (m_pc != 0 && guard < 2000) begin
      exec_instr(rand_alu(), 8'($urandom), 1'($urandom), 0);
      guard++;
    end
    check("wrap_guard", 32'(guard < 2000), 1);
    run_halt();

    // async reset in the middle of a store
    do_start();
    imem[0] = 9'b111_010_001;
    jiggle(); tick();
    jiggle(); tick();
    dmem_ack = 1'b0; alu_rslt = 8'h5A; start = 1'b0; tick();
    dmem_ack = 1'b0;
    check("pre_rst_req", 32'({dmem_req, dmem_we}), 32'b11);
    #2 reset = 1'b1;
    #1;
    check("rst_drop", 32'({dmem_req, rf_we, busy}), 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    do_start();
    exec_instr(9'b010_101_110, 8'h0F, 1'b1, 0);
    run_halt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
